neuron_mac_seq: RTL
===================

Name: neuron_mac_seq

Overview:
- Parametrised, time-multiplexed fixed-point neuron. It computes Y = act(sat(bias + sum(Xi*Wi))) over N_INPUTS signed Q(FRAC_BITS) inputs.
- Weights and bias are compile-time constants.
- One shared multiplier performs one MAC per cycle. The full-precision sum is shifted and saturated once, then the activation is applied.
- Input and output use valid/ready handshakes so neurons can be chained into layers. This is the generic replacement for the fixed 4-input, fixed-weight neurons in the network files.

Parameters:
- DATA_WIDTH, 8: width of inputs, weights, bias and output (signed, two's complement).
- FRAC_BITS, 4: fractional bits of the Q format shared by X, W, bias and Y.
- N_INPUTS, 4: number of inputs; legal range 1..64.
- WEIGHTS, {8'sd2, -8'sd4, 8'sd16, -8'sd7}: packed N_INPUTS*DATA_WIDTH vector. W0 occupies bits [DATA_WIDTH-1:0]; Wi occupies [i*DATA_WIDTH +: DATA_WIDTH].
- BIAS, 5: signed DATA_WIDTH bias in Q(FRAC_BITS).
- ACT_MODE, 0: 0 = ReLU, 1 = linear (identity).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  clock enable; while 0, all registers hold their values
- in_valid  in  1  x_flat is valid
- in_ready  out  1  high when the block can accept a sample
- x_flat  in  N_INPUTS*DATA_WIDTH  packed inputs; X0 in the LSBs, same packing as WEIGHTS
- out_valid  out  1  y is valid
- out_ready  in  1  downstream accepts y
- y  out  DATA_WIDTH  signed result
- busy  out  1  high in any state other than IDLE

Behaviour:
- ACC_W = 2*DATA_WIDTH + clog2(N_INPUTS) + 1. The accumulator is signed ACC_W bits and never overflows.
- Reset (async, asserted): state=IDLE, y=0, out_valid=0, acc=0, idx=0, input registers cleared.
- Reset mid-operation aborts the computation. No partial result is ever presented.
- States and transitions:
  - IDLE: in_ready = en. On in_valid && in_ready, latch x_flat, load acc = sign-extended BIAS <<< FRAC_BITS, load idx=0, go to MAC.
  - MAC: acc += Xidx * Widx (full 2*DATA_WIDTH product, sign-extended). Then idx++. After the idx = N_INPUTS-1 update, go to FINISH. This takes exactly N_INPUTS enabled cycles.
  - FINISH: r = acc >>> FRAC_BITS (arithmetic shift, floor toward -inf). Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Apply the activation: ReLU gives max(r,0); linear gives r. Register the result into y, set out_valid=1, go to OUT.
  - OUT: hold y and out_valid. On out_ready && en, clear out_valid and go to IDLE.
- y retains its last value after the handshake and only changes in FINISH.
- in_ready is 0 in every state except IDLE. in_valid outside IDLE is ignored, with no internal buffering.
- Latency: handshake accepted at enabled edge T gives out_valid=1 after enabled edge T+N_INPUTS+1.
- Throughput: at most one sample per N_INPUTS+3 cycles.
- en=0 freezes the state, idx, acc and outputs. in_ready reads 0 while en=0. Latency is extended by the number of disabled cycles.
- out_ready is sampled only in OUT. out_ready held high continuously gives a one-cycle out_valid pulse.
- Default states (illegal encodings) go to IDLE with out_valid=0.
- N_INPUTS=1: a single MAC cycle, no other change.

Test Plan:
- Defaults (W=-7,16,-4,2, BIAS=5, ReLU), X=(16,16,16,16) → acc=192, y=12. out_valid rises exactly 5 enabled cycles after the accept edge.
- X=(12,0,0,0), ACT_MODE=1 → acc=-4, y=-1 (floor). With ACT_MODE=0, same X → y=0. X=(32,0,0,0) with ReLU → y=0.
- X=(0,127,0,0) → r=132, saturates to y=127. Saturation to -128 in linear mode: X=(127,0,0,0) with WEIGHTS W0=-128, BIAS=-128, ACT_MODE=1 → acc=-18304, r=-1144, y=-128.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 with new data. Required: y and out_valid stable, in_ready=0, new data not taken. After out_ready=1, the next sample is accepted in IDLE one cycle later.
- Assert rst during the second MAC cycle, then release, then send X=(16,16,16,16) → no out_valid from the aborted op, then y=12 with normal latency.
- Drop en for 3 cycles mid-MAC → result unchanged (y=12), out_valid delayed by exactly 3 cycles. N_INPUTS=1 build with W0=16, BIAS=0, X0=-32, linear → y=-32 after 2 cycles.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: time-multiplexed fixed-point neuron.
//   y = act(sat((BIAS <<< FRAC_BITS + sum Xi*Wi) >>> FRAC_BITS))
// A single shared multiplier does one MAC per enabled cycle. The full-precision
// sum is shifted and saturated once at the end, then the activation is applied.
// Ports:
//   clk, rst        clock, async active-high reset
//   en              clock enable, all state holds while low
//   in_valid/ready  input handshake, x_flat packed with X0 in the LSBs
//   out_valid/ready output handshake, y signed DATA_WIDTH result
//   busy            high whenever the block is not idle
module neuron_mac_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int N_INPUTS   = 4,
  parameter logic [N_INPUTS*DATA_WIDTH-1:0] WEIGHTS = {8'sd2, -8'sd4, 8'sd16, -8'sd7},
  parameter logic signed [DATA_WIDTH-1:0] BIAS = 5,
  parameter int ACT_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] x_flat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          y,
  output logic                           busy
);

  // Wide enough that N full products plus the shifted bias cannot overflow.
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(N_INPUTS) + 1;
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic signed [ACC_W-1:0] BIAS_ACC = ACC_W'(BIAS) <<< FRAC_BITS;
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAC    = 2'd1,
    S_FINISH = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic [N_INPUTS*DATA_WIDTH-1:0]  x_q, x_d;
  logic [DATA_WIDTH-1:0]           y_q, y_d;
  logic                            out_valid_q, out_valid_d;

  logic signed [DATA_WIDTH-1:0]    x_sel, w_sel;
  logic signed [2*DATA_WIDTH-1:0]  prod;
  logic signed [ACC_W-1:0]         shr;
  logic [DATA_WIDTH-1:0]           sat, act;

  assign x_sel = x_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel = WEIGHTS[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign prod  = x_sel * w_sel;

  // Arithmetic shift floors toward -inf, then clamp to the output range.
  assign shr = acc_q >>> FRAC_BITS;

  always_comb begin
    sat = shr[DATA_WIDTH-1:0];
    if (shr > Y_MAX)      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (shr < Y_MIN) sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end

  always_comb begin
    act = sat;
    if (ACT_MODE == 0 && sat[DATA_WIDTH-1]) act = '0;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_d     = x_flat;
            acc_d   = BIAS_ACC;
            idx_d   = '0;
            state_d = S_MAC;
          end
        end
        S_MAC: begin
          acc_d = acc_q + ACC_W'(prod);
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(N_INPUTS-1)) state_d = S_FINISH;
        end
        S_FINISH: begin
          y_d         = act;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = en && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = (state_q != S_IDLE);

endmodule
